// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, forwarding select encoding and operand-usage helpers.
// Used by the forwarding/hazard unit and its operand selector.
package core_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_PIM    = 7'b0001011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  localparam int unsigned FWD_SEL_RF = 32'd1;

  function automatic int unsigned fwd_sel_stage(input int unsigned k);
    return k + 32'd2;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    logic r;
    case (op)
      OPCODE_JAL, OPCODE_LUI, OPCODE_AUIPC: r = 1'b0;
      default:                              r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    logic r;
    case (op)
      OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH, OPCODE_PIM: r = 1'b1;
      default:                                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Forward-source selection for one ID operand: youngest matching stage wins,
// falling back to the register file; flags a RAW hazard when the value is not yet available.
module fwd_operand_sel
  import core_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = 2,
  parameter int PEND_W  = 2
) (
  input  logic                 used_i,
  input  logic [4:0]           rs_i,
  input  logic [NUM_FWD-1:0]   fwd_valid_i,
  input  logic [NUM_FWD*5-1:0] fwd_rd_i,
  input  logic [NUM_FWD-1:0]   fwd_ready_i,
  input  logic [PEND_W-1:0]    pend_i,
  output logic [SEL_W-1:0]     sel_o,
  output logic                 hazard_o
);

  logic             found_s;
  logic             hit_ready_s;
  logic [SEL_W-1:0] hit_sel_s;
  logic             match_s;

  // Priority search, ascending index so the first (youngest) match is kept.
  always_comb begin
    found_s     = 1'b0;
    hit_ready_s = 1'b0;
    hit_sel_s   = SEL_W'(FWD_SEL_RF);
    match_s     = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      match_s     = fwd_valid_i[k] && (fwd_rd_i[5*k +: 5] == rs_i);
      hit_ready_s = (match_s && !found_s) ? fwd_ready_i[k] : hit_ready_s;
      hit_sel_s   = (match_s && !found_s) ? SEL_W'(fwd_sel_stage(k)) : hit_sel_s;
      found_s     = found_s | match_s;
    end
  end

  always_comb begin
    sel_o    = SEL_W'(FWD_SEL_RF);
    hazard_o = 1'b0;
    if (!used_i || (rs_i == 5'd0)) begin
      sel_o    = SEL_W'(FWD_SEL_RF);
      hazard_o = 1'b0;
    end else if (found_s) begin
      sel_o    = hit_ready_s ? hit_sel_s : SEL_W'(FWD_SEL_RF);
      hazard_o = !hit_ready_s;
    end else begin
      // Not in any forwarding stage: still outstanding in a long-latency unit?
      sel_o    = SEL_W'(FWD_SEL_RF);
      hazard_o = (pend_i != '0);
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage operand forwarding and hazard detection with a per-register scoreboard
// of outstanding long-latency (LOAD/PIM) writes and a saturating stall counter.
module fwd_hazard_unit
  import core_pkg::*;
#(
  parameter int NUM_FWD  = 2,
  parameter int NREG     = 32,
  parameter int PEND_MAX = 3,
  localparam int PEND_W  = $clog2(PEND_MAX + 1),
  localparam int SEL_W   = $clog2(NUM_FWD + 2)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [6:0]           id_opcode_i,
  input  logic [4:0]           id_rs1_i,
  input  logic [4:0]           id_rs2_i,
  input  logic                 issue_i,
  input  logic [4:0]           issue_rd_i,
  input  logic                 issue_long_i,
  input  logic [NUM_FWD-1:0]   fwd_valid_i,
  input  logic [NUM_FWD*5-1:0] fwd_rd_i,
  input  logic [NUM_FWD-1:0]   fwd_ready_i,
  input  logic                 wb_long_done_i,
  input  logic [4:0]           wb_rd_i,
  input  logic                 flush_i,
  output logic [SEL_W-1:0]     forward_a_o,
  output logic [SEL_W-1:0]     forward_b_o,
  output logic                 stall_o,
  output logic                 busy_o,
  output logic [31:0]          stall_cnt_o
);

  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic [31:0]       stall_cnt_q;
  logic [31:0]       stall_cnt_d;

  logic hazard_a_s;
  logic hazard_b_s;
  logic struct_s;
  logic inc_s;
  logic dec_s;
  logic busy_s;

  fwd_operand_sel #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W), .PEND_W(PEND_W)) u_sel_a (
    .used_i      (uses_rs1(id_opcode_i)),
    .rs_i        (id_rs1_i),
    .fwd_valid_i (fwd_valid_i),
    .fwd_rd_i    (fwd_rd_i),
    .fwd_ready_i (fwd_ready_i),
    .pend_i      (pend_q[id_rs1_i]),
    .sel_o       (forward_a_o),
    .hazard_o    (hazard_a_s)
  );

  fwd_operand_sel #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W), .PEND_W(PEND_W)) u_sel_b (
    .used_i      (uses_rs2(id_opcode_i)),
    .rs_i        (id_rs2_i),
    .fwd_valid_i (fwd_valid_i),
    .fwd_rd_i    (fwd_rd_i),
    .fwd_ready_i (fwd_ready_i),
    .pend_i      (pend_q[id_rs2_i]),
    .sel_o       (forward_b_o),
    .hazard_o    (hazard_b_s)
  );

  // Stall decision and scoreboard update enables.
  always_comb begin
    struct_s = issue_long_i && (pend_q[issue_rd_i] == PEND_W'(PEND_MAX));
    stall_o  = (hazard_a_s | hazard_b_s | struct_s) & !flush_i;
    inc_s    = issue_i && !stall_o && !flush_i && issue_long_i && (issue_rd_i != 5'd0);
    dec_s    = wb_long_done_i && (wb_rd_i != 5'd0) && (pend_q[wb_rd_i] != '0);
  end

  // Per-register next count; a simultaneous inc and dec on one register cancel out.
  always_comb begin
    busy_s = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      pend_d[i] = pend_q[i]
                + ((inc_s && (issue_rd_i == 5'(i))) ? PEND_W'(1) : PEND_W'(0))
                - ((dec_s && (wb_rd_i    == 5'(i))) ? PEND_W'(1) : PEND_W'(0));
      busy_s    = busy_s | (pend_q[i] != '0);
    end
    stall_cnt_d = (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  // Scoreboard and stall counter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        pend_q[i] <= '0;
      end
      stall_cnt_q <= 32'd0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        pend_q[i] <= pend_d[i];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_o      = busy_s;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (NUM_FWD=2, PEND_MAX=3).
module tb_fwd_hazard_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1, id_rs2;
  logic        issue, issue_long;
  logic [4:0]  issue_rd;
  logic [1:0]  fwd_valid, fwd_ready;
  logic [9:0]  fwd_rd;
  logic        wb_long_done;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [1:0]  forward_a, forward_b;
  logic        stall, busy;
  logic [31:0] stall_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NUM_FWD(2), .NREG(32), .PEND_MAX(3)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_opcode_i    (id_opcode),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .issue_i        (issue),
    .issue_rd_i     (issue_rd),
    .issue_long_i   (issue_long),
    .fwd_valid_i    (fwd_valid),
    .fwd_rd_i       (fwd_rd),
    .fwd_ready_i    (fwd_ready),
    .wb_long_done_i (wb_long_done),
    .wb_rd_i        (wb_rd),
    .flush_i        (flush),
    .forward_a_o    (forward_a),
    .forward_b_o    (forward_b),
    .stall_o        (stall),
    .busy_o         (busy),
    .stall_cnt_o    (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; id_opcode = OP_R; id_rs1 = 5'd0; id_rs2 = 5'd0;
    issue = 1'b0; issue_long = 1'b0; issue_rd = 5'd0;
    fwd_valid = 2'b00; fwd_ready = 2'b00; fwd_rd = 10'd0;
    wb_long_done = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    step(); step();
    rst = 1'b0;
    settle();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cnt", stall_cnt, 32'd0);
    check("rst_fa", {30'd0, forward_a}, 32'd1);

    // 1: stage0 ready match on both operands
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd5}; fwd_ready = 2'b01;
    id_rs1 = 5'd5; id_rs2 = 5'd5;
    settle();
    check("t1_fa", {30'd0, forward_a}, 32'd2);
    check("t1_fb", {30'd0, forward_b}, 32'd2);
    check("t1_stall", {31'd0, stall}, 32'd0);

    // 2: stage0 not ready shadows ready stage1
    fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_ready = 2'b10;
    settle();
    check("t2_fa", {30'd0, forward_a}, 32'd1);
    check("t2_stall", {31'd0, stall}, 32'd1);
    step();
    fwd_ready = 2'b11;
    settle();
    check("t2_fa_rdy", {30'd0, forward_a}, 32'd2);
    check("t2_fb_rdy", {30'd0, forward_b}, 32'd2);
    check("t2_stall_rdy", {31'd0, stall}, 32'd0);
    check("t2_cnt", stall_cnt, 32'd1);
    // only stage1 valid -> select 3
    fwd_valid = 2'b10;
    settle();
    check("t2_fa_s1", {30'd0, forward_a}, 32'd3);

    // 3: LW x7 then SW using x7 as rs2
    fwd_valid = 2'b00; fwd_ready = 2'b00; fwd_rd = 10'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    issue = 1'b1; issue_rd = 5'd7; issue_long = 1'b1;
    step();
    issue = 1'b0; issue_long = 1'b0;
    id_opcode = OP_STORE; id_rs2 = 5'd7;
    settle();
    check("t3_busy", {31'd0, busy}, 32'd1);
    check("t3_stall", {31'd0, stall}, 32'd1);
    check("t3_fb", {30'd0, forward_b}, 32'd1);
    step(); step();
    check("t3_cnt", stall_cnt, 32'd3);
    wb_long_done = 1'b1; wb_rd = 5'd7;
    settle();
    check("t3_stall_wb", {31'd0, stall}, 32'd1);
    step();
    wb_long_done = 1'b0;
    settle();
    check("t3_stall_done", {31'd0, stall}, 32'd0);
    check("t3_busy_done", {31'd0, busy}, 32'd0);
    check("t3_cnt_done", stall_cnt, 32'd4);

    // 4: x0 everywhere
    id_opcode = OP_R; id_rs1 = 5'd0; id_rs2 = 5'd0;
    fwd_valid = 2'b11; fwd_rd = 10'd0; fwd_ready = 2'b00;
    settle();
    check("t4_fa", {30'd0, forward_a}, 32'd1);
    check("t4_fb", {30'd0, forward_b}, 32'd1);
    check("t4_stall", {31'd0, stall}, 32'd0);
    issue = 1'b1; issue_rd = 5'd0; issue_long = 1'b1;
    step();
    issue = 1'b0; issue_long = 1'b0;
    settle();
    check("t4_busy", {31'd0, busy}, 32'd0);

    // 5: fill x9 to PEND_MAX, then structural stall
    fwd_valid = 2'b00;
    issue = 1'b1; issue_rd = 5'd9; issue_long = 1'b1;
    step(); step(); step();
    check("t5_struct", {31'd0, stall}, 32'd1);
    check("t5_cnt0", stall_cnt, 32'd4);
    step();
    check("t5_cnt1", stall_cnt, 32'd5);
    wb_long_done = 1'b1; wb_rd = 9;
    step();
    check("t5_after_ret", {31'd0, stall}, 32'd0);
    check("t5_cnt2", stall_cnt, 32'd6);
    step();
    check("t5_inc_dec", {31'd0, stall}, 32'd0);
    wb_long_done = 1'b0;
    step();
    check("t5_full_again", {31'd0, stall}, 32'd1);
    issue = 1'b0; issue_long = 1'b0;
    wb_long_done = 1'b1; wb_rd = 5'd9;
    step(); step(); step();
    check("t5_drained", {31'd0, busy}, 32'd0);
    step();
    check("t5_no_wrap", {31'd0, busy}, 32'd0);
    wb_long_done = 1'b0;
    check("t5_cnt3", stall_cnt, 32'd6);

    // 6: LUI ignores rs1, flush suppresses stall and counting
    issue = 1'b1; issue_rd = 5'd5; issue_long = 1'b1;
    step();
    issue = 1'b0; issue_long = 1'b0;
    id_opcode = OP_LUI; id_rs1 = 5'd5; id_rs2 = 5'd5;
    settle();
    check("t6_lui_fa", {30'd0, forward_a}, 32'd1);
    check("t6_lui_stall", {31'd0, stall}, 32'd0);
    id_opcode = OP_JAL;
    settle();
    check("t6_jal_stall", {31'd0, stall}, 32'd0);
    id_opcode = OP_R;
    settle();
    check("t6_r_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    settle();
    check("t6_flush_stall", {31'd0, stall}, 32'd0);
    step(); step();
    check("t6_flush_cnt", stall_cnt, 32'd6);
    check("t6_flush_busy", {31'd0, busy}, 32'd1);
    flush = 1'b0;
    step();
    check("t6_cnt_resume", stall_cnt, 32'd7);

    // reset mid-operation discards pending
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("rst2_busy", {31'd0, busy}, 32'd0);
    check("rst2_stall", {31'd0, stall}, 32'd0);
    check("rst2_cnt", stall_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
